// File: rtl/key_schedule_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl_if
// Description : Bundle between the cipher control / key-register datapath and
//               the key schedule sequencer. The master side issues start
//               (and stall when KEYCTRL_STALL_EN is defined); the slave side
//               is the sequencer, which drives the strobes and status.
// Options     : KEYCTRL_STALL_EN adds the stall signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_schedule_ctrl_if;

    logic       start;
`ifdef KEYCTRL_STALL_EN
    logic       stall;
`endif
    logic       en;
    logic       doSboxIn;
    logic       doFirstSubkey;
    logic       doKeyFirstCol;
    logic       doKeyOtherCol;
    logic       keyLoadReady;
    logic [7:0] rcon;
    logic       rconValid;
    logic       subkeyValid;
    logic [3:0] round;
    logic [3:0] byteIdx;
    logic       busy;
    logic       done;

    // Cipher control side: requests schedules, observes strobes and status
    modport master (
        output start,
`ifdef KEYCTRL_STALL_EN
        output stall,
`endif
        input  en,
        input  doSboxIn,
        input  doFirstSubkey,
        input  doKeyFirstCol,
        input  doKeyOtherCol,
        input  keyLoadReady,
        input  rcon,
        input  rconValid,
        input  subkeyValid,
        input  round,
        input  byteIdx,
        input  busy,
        input  done
    );

    // Sequencer side
    modport slave (
        input  start,
`ifdef KEYCTRL_STALL_EN
        input  stall,
`endif
        output en,
        output doSboxIn,
        output doFirstSubkey,
        output doKeyFirstCol,
        output doKeyOtherCol,
        output keyLoadReady,
        output rcon,
        output rconValid,
        output subkeyValid,
        output round,
        output byteIdx,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl
// Description : Sequencer for the byte-serial AES-128 key-register unit.
//               Runs key load (16 cycles), round-key-0 emission (16 cycles)
//               and ten expansion rounds (SBOX 4, FCOL 4, OCOL 12 cycles),
//               generating the round constant and round-key-byte valid.
// Options     : KEYCTRL_STALL_EN - adds a stall input that freezes the
//               schedule and masks every strobe while high.
// Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_ctrl (
    input  wire logic           clk,
    input  wire logic           rst_n,
    key_schedule_ctrl_if.slave  ctrl
);

    // ------------------------------------------------------------------------
    // State encoding and phase lengths (expressed as last byteIdx value)
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FIRST = 3'd2;
    localparam logic [2:0] S_SBOX  = 3'd3;
    localparam logic [2:0] S_FCOL  = 3'd4;
    localparam logic [2:0] S_OCOL  = 3'd5;

    localparam logic [3:0] LOAD_LAST  = 4'd15;
    localparam logic [3:0] FIRST_LAST = 4'd15;
    localparam logic [3:0] SBOX_LAST  = 4'd3;
    localparam logic [3:0] FCOL_LAST  = 4'd3;
    localparam logic [3:0] OCOL_LAST  = 4'd11;
    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    // GF(2^8) multiply-by-two used to step the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [2:0] state_q,    state_d;
    logic [3:0] byte_idx_q, byte_idx_d;
    logic [3:0] round_q,    round_d;
    logic [7:0] rcon_q,     rcon_d;
    logic       done_q,     done_d;

    logic       stall_w;
    logic       start_req_w;

`ifdef KEYCTRL_STALL_EN
    // A start that arrives while stalled in IDLE is remembered and accepted
    // once the stall drops, so a one-cycle request is never lost.
    logic       start_pend_q, start_pend_d;

    assign stall_w     = ctrl.stall;
    assign start_req_w = ctrl.start | start_pend_q;

    // Remember a start request seen in IDLE while stalled
    always_comb begin
        start_pend_d = start_pend_q;
        if (state_q == S_IDLE && stall_w && ctrl.start && !done_q) begin
            start_pend_d = 1'b1;
        end
        if (state_q == S_IDLE && state_d == S_LOAD) begin
            start_pend_d = 1'b0;
        end
    end

    // Pending-start register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend_q <= 1'b0;
        end else begin
            start_pend_q <= start_pend_d;
        end
    end
`else
    assign stall_w     = 1'b0;
    assign start_req_w = ctrl.start;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic: byteIdx counts within a phase and clears on every
    // phase change; a stall holds everything, including a pending done pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        done_d     = 1'b0;

        if (stall_w) begin
            done_d = done_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // The done cycle is already IDLE, but a start coinciding
                    // with it is dropped so back-to-back runs need a gap.
                    if (start_req_w && !done_q) begin
                        state_d    = S_LOAD;
                        byte_idx_d = 4'd0;
                        round_d    = 4'd0;
                    end
                end
                S_LOAD: begin
                    if (byte_idx_q == LOAD_LAST) begin
                        state_d    = S_FIRST;
                        byte_idx_d = 4'd0;
                        round_d    = 4'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                S_FIRST: begin
                    if (byte_idx_q == FIRST_LAST) begin
                        state_d    = S_SBOX;
                        byte_idx_d = 4'd0;
                        round_d    = 4'd1;
                        rcon_d     = RCON_INIT;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                S_SBOX: begin
                    if (byte_idx_q == SBOX_LAST) begin
                        state_d    = S_FCOL;
                        byte_idx_d = 4'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                S_FCOL: begin
                    if (byte_idx_q == FCOL_LAST) begin
                        state_d    = S_OCOL;
                        byte_idx_d = 4'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                S_OCOL: begin
                    if (byte_idx_q == OCOL_LAST) begin
                        byte_idx_d = 4'd0;
                        if (round_q == LAST_ROUND) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_SBOX;
                            round_d = round_q + 4'd1;
                            rcon_d  = xtime(rcon_q);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    byte_idx_d = 4'd0;
                end
            endcase
        end
    end

    // State, counters, round constant and completion pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 4'd0;
            round_q    <= 4'd0;
            rcon_q     <= RCON_INIT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode: strobes come only from registered state, so exactly one
    // of them can be high; stall masks them without touching the state.
    // ------------------------------------------------------------------------
    logic run_w;
    assign run_w = !stall_w;

    assign ctrl.en            = run_w && (state_q == S_LOAD);
    assign ctrl.keyLoadReady  = run_w && (state_q == S_LOAD);
    assign ctrl.doFirstSubkey = run_w && (state_q == S_FIRST);
    assign ctrl.doSboxIn      = run_w && (state_q == S_SBOX);
    assign ctrl.doKeyFirstCol = run_w && (state_q == S_FCOL);
    assign ctrl.doKeyOtherCol = run_w && (state_q == S_OCOL);
    assign ctrl.subkeyValid   = run_w && ((state_q == S_FIRST) ||
                                          (state_q == S_FCOL)  ||
                                          (state_q == S_OCOL));
    assign ctrl.rconValid     = run_w && (state_q == S_FCOL) && (byte_idx_q == 4'd0);
    assign ctrl.rcon          = rcon_q;
    assign ctrl.round         = round_q;
    assign ctrl.byteIdx       = byte_idx_q;
    assign ctrl.busy          = (state_q != S_IDLE);
    assign ctrl.done          = run_w && done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_schedule_ctrl
// Description : Self-checking bench for key_schedule_ctrl. Expected per-cycle
//               outputs are derived from the cycle-numbered schedule and
//               queued when a run is started; rcon values are queued with the
//               cycle at which their rconValid pulse must appear.
// Options     : KEYCTRL_STALL_EN enables the stall scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_schedule_ctrl_if ks_if ();

    key_schedule_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ks_if.slave)
    );

    // flags: [9]en [8]sbox [7]first [6]fcol [5]ocol [4]klr [3]sv [2]rv [1]busy [0]done
    typedef struct packed {
        logic [9:0] flags;
        logic [3:0] idx;
        logic [3:0] rnd;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } rcon_t;

    exp_t  exp_q[$];
    rcon_t rcon_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int sv_count = 0;

    // Expected outputs at cycle c after the accepted start (c = 0 is the
    // start cycle), built from the documented cycle map.
    function automatic exp_t exp_at(int c, logic [3:0] idle_rnd);
        exp_t e;
        int   d;
        int   p;
        e = '0;
        if (c <= 0) begin
            e.rnd = idle_rnd;
        end else if (c >= 233) begin
            e.rnd = 4'd10;
            if (c == 233) e.flags[0] = 1'b1;
        end else begin
            e.flags[1] = 1'b1;
            if (c <= 16) begin
                e.flags[9] = 1'b1;
                e.flags[4] = 1'b1;
                e.idx      = 4'(c - 1);
            end else if (c <= 32) begin
                e.flags[7] = 1'b1;
                e.flags[3] = 1'b1;
                e.idx      = 4'(c - 17);
            end else begin
                d     = c - 33;
                p     = d % 20;
                e.rnd = 4'(d / 20 + 1);
                if (p < 4) begin
                    e.flags[8] = 1'b1;
                    e.idx      = 4'(p);
                end else if (p < 8) begin
                    e.flags[6] = 1'b1;
                    e.flags[3] = 1'b1;
                    e.flags[2] = (p == 4);
                    e.idx      = 4'(p - 4);
                end else begin
                    e.flags[5] = 1'b1;
                    e.flags[3] = 1'b1;
                    e.idx      = 4'(p - 8);
                end
            end
        end
        return e;
    endfunction

    // Stall held for cycles 40..44: outputs frozen at FCOL byte 3 with all
    // strobes masked, then the schedule resumes five cycles late.
    function automatic exp_t exp_stall(int c, logic [3:0] idle_rnd);
        exp_t e;
        if (c >= 40 && c <= 44) begin
            e       = '0;
            e.flags = 10'b00_0000_0010;
            e.idx   = 4'd3;
            e.rnd   = 4'd1;
        end else if (c > 44) begin
            e = exp_at(c - 5, idle_rnd);
        end else begin
            e = exp_at(c, idle_rnd);
        end
        return e;
    endfunction

    function automatic logic [9:0] obs_flags();
        return {ks_if.en, ks_if.doSboxIn, ks_if.doFirstSubkey, ks_if.doKeyFirstCol,
                ks_if.doKeyOtherCol, ks_if.keyLoadReady, ks_if.subkeyValid,
                ks_if.rconValid, ks_if.busy, ks_if.done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // Expected rcon values 01..36; rounds after the first shift by 'shift'.
    task automatic push_rcon(input int shift);
        logic [7:0] v;
        rcon_t      r;
        v = 8'h01;
        for (int k = 0; k < 10; k++) begin
            r.cyc = 37 + 20 * k + ((k > 0) ? shift : 0);
            r.val = v;
            rcon_q.push_back(r);
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
        end
    endtask

    task automatic cycle_check();
        exp_t       e;
        logic [9:0] f;
        rcon_t      r;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        f = obs_flags();
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("flags",   32'(f),             32'(e.flags));
            chk("byteIdx", 32'(ks_if.byteIdx), 32'(e.idx));
            chk("round",   32'(ks_if.round),   32'(e.rnd));
        end
        chk("strobe_excl", 32'($countones(f[9:5]) <= 1), 32'd1);
        if (ks_if.subkeyValid) sv_count++;
        if (ks_if.rconValid) begin
            chk("rcon_expected", 32'(rcon_q.size() != 0), 32'd1);
            if (rcon_q.size() != 0) begin
                r = rcon_q.pop_front();
                chk("rcon_val",   32'(ks_if.rcon), 32'(r.val));
                chk("rcon_cycle", 32'(cyc),        32'(r.cyc));
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_flags"},   32'(obs_flags()),   32'd0);
        chk({tag, "_rcon"},    32'(ks_if.rcon),    32'h01);
        chk({tag, "_round"},   32'(ks_if.round),   32'd0);
        chk({tag, "_byteIdx"}, 32'(ks_if.byteIdx), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hard bound on simulation time
    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    initial begin
        ks_if.start = 1'b0;
`ifdef KEYCTRL_STALL_EN
        ks_if.stall = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run A: nominal run with extra starts at 50 (busy) and 233 (done)
        for (int c = 0; c < 240; c++) exp_q.push_back(exp_at(c, 4'd0));
        push_rcon(0);
        sv_count = 0;
        cyc      = 0;
        for (int c = 0; c < 240; c++) begin
            ks_if.start = (c == 0 || c == 50 || c == 233);
            #1;
            cycle_check();
            step();
        end
        ks_if.start = 1'b0;
        chk("runA_subkeyValid_count", 32'(sv_count),      32'd176);
        chk("runA_rcon_consumed",     32'(rcon_q.size()), 32'd0);

        // Run B: fresh start at 240, then asynchronous reset in round 4
        for (int c = 0; c < 100; c++) exp_q.push_back(exp_at(c, 4'd10));
        push_rcon(0);
        cyc = 0;
        for (int c = 0; c < 100; c++) begin
            ks_if.start = (c == 0);
            #1;
            cycle_check();
            step();
        end
        ks_if.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        chk("midrst_rcon_pulses", 32'(rcon_q.size()), 32'd6);
        rcon_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Run C: nominal timing repeats after reset
        for (int c = 0; c < 236; c++) exp_q.push_back(exp_at(c, 4'd0));
        push_rcon(0);
        sv_count = 0;
        cyc      = 0;
        for (int c = 0; c < 236; c++) begin
            ks_if.start = (c == 0);
            #1;
            cycle_check();
            step();
        end
        ks_if.start = 1'b0;
        chk("runC_subkeyValid_count", 32'(sv_count),      32'd176);
        chk("runC_rcon_consumed",     32'(rcon_q.size()), 32'd0);

`ifdef KEYCTRL_STALL_EN
        // Run D: stall for cycles 40..44 during FCOL; done moves to 238
        for (int c = 0; c < 241; c++) exp_q.push_back(exp_stall(c, 4'd10));
        push_rcon(5);
        sv_count = 0;
        cyc      = 0;
        for (int c = 0; c < 241; c++) begin
            ks_if.start = (c == 0);
            ks_if.stall = (c >= 40 && c <= 44);
            #1;
            cycle_check();
            step();
        end
        ks_if.start = 1'b0;
        ks_if.stall = 1'b0;
        chk("runD_subkeyValid_count", 32'(sv_count),      32'd176);
        chk("runD_rcon_consumed",     32'(rcon_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
